// File: rtl/switch_debounce_conditioner_pkg.sv
// Shared timing constants for the slide-switch conditioner.
// Default debounce window is DEBOUNCE_MS of core clock cycles.
package switch_debounce_conditioner_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int DEBOUNCE_CYCLES_DFLT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: saturating agreement counter, stable level flop, rise/fall pulse flops.
// stable_o moves only after DC consecutive mismatching samples; flip_o is the pulse next-state.
module switch_debounce_bit
  import switch_debounce_conditioner_pkg::*;
#(
  parameter int DC    = DEBOUNCE_CYCLES_DFLT,
  parameter int CNT_W = $clog2(DC + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic s_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic flip_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Any sample agreeing with the stable level restarts the whole window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s_i != stable_q) begin
      if (cnt_q == CNT_W'(DC - 1)) begin
        stable_d = s_i;
        rise_d   = s_i;
        fall_d   = ~s_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign flip_o   = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce_conditioner.sv
// Synchronizes and debounces raw slide switches ahead of the switch PIO.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges; pulses and sw_change coincide with sw_stable updates.
module switch_debounce_conditioner
  import switch_debounce_conditioner_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  flip;
  logic                              change_q, change_d;

  // Index 0 is the metastability-catching stage; the last stage feeds the counters.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DC    (DEBOUNCE_CYCLES),
      .CNT_W (CNT_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_i      (sync_q[SYNC_STAGES-1][i]),
      .stable_o (sw_stable[i]),
      .rise_o   (sw_rise[i]),
      .fall_o   (sw_fall[i]),
      .flip_o   (flip[i])
    );
  end

  // Built from the pulse next-state so it lands on the same edge as the pulses.
  assign change_d = |flip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      change_q <= 1'b0;
    end else begin
      change_q <= change_d;
    end
  end

  assign sw_change = change_q;

endmodule
